// File: rtl/sap_ctrl_pkg.sv
// Shared opcode encodings and control-word bit map for the SAP-1 style micro sequencer.
package sap_ctrl_pkg;

    typedef enum logic [3:0] {
        LDA = 4'h0,
        ADD = 4'h1,
        SUB = 4'h2,
        JMP = 4'h3,
        JZ  = 4'h4,
        JN  = 4'h5,
        OUT = 4'hE,
        HLT = 4'hF
    } opcode_e;

    localparam int unsigned CP = 0;
    localparam int unsigned EP = 1;
    localparam int unsigned LM = 2;
    localparam int unsigned CE = 3;
    localparam int unsigned LI = 4;
    localparam int unsigned EI = 5;
    localparam int unsigned LA = 6;
    localparam int unsigned EA = 7;
    localparam int unsigned SU = 8;
    localparam int unsigned EU = 9;
    localparam int unsigned LB = 10;
    localparam int unsigned LO = 11;
    localparam int unsigned LP = 12;

    localparam int unsigned CW_W = 13;
    typedef logic [CW_W-1:0] cw_t;

    // Pass the same index twice for a single-bit word.
    function automatic cw_t cw_bits(input int unsigned a, input int unsigned b);
        cw_t w;
        w    = '0;
        w[a] = 1'b1;
        w[b] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/micro_sequencer_tstate_ring.sv
// One-hot T-state ring; restart or a corrupted encoding reloads T1 on the next advance.
module tstate_ring #(
    parameter int unsigned MAX_T = 6
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             en_i,
    input  logic             restart_i,
    output logic [MAX_T-1:0] t_o,
    output logic             legal_o
);

    logic [MAX_T-1:0] t_q, t_d;
    logic             legal;

    always_comb begin
        legal = (t_q != '0) && ((t_q & (t_q - MAX_T'(1))) == '0);
        t_d   = t_q;
        if (en_i) begin
            if (restart_i || !legal) begin
                t_d = MAX_T'(1);
            end else begin
                t_d = {t_q[MAX_T-2:0], t_q[MAX_T-1]};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            t_q <= MAX_T'(1);
        end else begin
            t_q <= t_d;
        end
    end

    assign t_o     = t_q;
    assign legal_o = legal;

endmodule

// File: rtl/micro_sequencer.sv
// Clock-enabled variable-length controller/sequencer with conditional jumps, sticky halt
// and a retired-instruction counter.
module micro_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int unsigned MAX_T = 6,
    parameter int unsigned OP_W  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             run,
    input  logic             step,
    input  logic [OP_W-1:0]  opcode,
    input  logic             flag_z,
    input  logic             flag_n,
    output logic [CW_W-1:0]  ctrl_word,
    output logic             cw_valid,
    output logic [MAX_T-1:0] t_state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    if (MAX_T < 6) begin : g_bad_max_t
        $error("micro_sequencer: MAX_T must be >= 6");
    end

    logic             halted_q;
    logic [CNT_W-1:0] retired_q;
    logic [MAX_T-1:0] t_q;
    logic             legal;
    logic             adv;
    logic             fin;
    logic             hlt;
    logic             retire;
    cw_t              cw;

    assign adv = (run | step) & ~halted_q & ~CLR;

    always_comb begin
        cw  = '0;
        fin = 1'b0;
        hlt = 1'b0;
        if (legal) begin
            if (t_q[0]) begin
                cw = cw_bits(EP, LM);
            end else if (t_q[1]) begin
                cw = cw_bits(CP, CP);
            end else if (t_q[2]) begin
                cw = cw_bits(CE, LI);
            end else if (t_q[3]) begin
                fin = 1'b1;
                case (opcode)
                    OP_W'(LDA), OP_W'(ADD), OP_W'(SUB): begin
                        cw  = cw_bits(EI, LM);
                        fin = 1'b0;
                    end
                    OP_W'(JMP): cw = cw_bits(EI, LP);
                    OP_W'(JZ):  cw = flag_z ? cw_bits(EI, LP) : '0;
                    OP_W'(JN):  cw = flag_n ? cw_bits(EI, LP) : '0;
                    OP_W'(OUT): cw = cw_bits(EA, LO);
                    OP_W'(HLT): begin
                        hlt = 1'b1;
                        fin = 1'b0;
                    end
                    default: ;
                endcase
            end else if (t_q[4]) begin
                case (opcode)
                    OP_W'(LDA): begin
                        cw  = cw_bits(CE, LA);
                        fin = 1'b1;
                    end
                    OP_W'(ADD), OP_W'(SUB): cw = cw_bits(CE, LB);
                    default: ;
                endcase
            end else if (t_q[5]) begin
                case (opcode)
                    OP_W'(ADD): begin
                        cw  = cw_bits(EU, LA);
                        fin = 1'b1;
                    end
                    OP_W'(SUB): begin
                        cw     = cw_bits(EU, LA);
                        cw[SU] = 1'b1;
                        fin    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The top state always restarts, so an opcode that never ends still retires there.
    assign retire = adv & legal & (fin | t_q[MAX_T-1]);

    tstate_ring #(.MAX_T(MAX_T)) u_ring (
        .CLK       (CLK),
        .CLR       (CLR),
        .en_i      (adv & ~hlt),
        .restart_i (fin | t_q[MAX_T-1]),
        .t_o       (t_q),
        .legal_o   (legal)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            if (adv && hlt) begin
                halted_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign ctrl_word = adv ? cw : '0;
    assign cw_valid  = adv;
    assign t_state   = t_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule
